// File: rtl/ether_rx.sv
// MII receive MAC front-end: preamble/SFD detection, CRC-32 check, single-frame
// buffer and a small host command port for size, data, release and drop count.
module ether_rx #(
  parameter logic [3:0]  ERX_CMD_GETSIZE = 4'd1,
  parameter logic [3:0]  ERX_CMD_GETDATA = 4'd2,
  parameter logic [3:0]  ERX_CMD_RELEASE = 4'd3,
  parameter logic [3:0]  ERX_CMD_GETDROP = 4'd4,
  parameter int unsigned MAX_BYTES       = 2048
) (
  input  logic        erx_clk,
  input  logic        erx_rst,
  input  logic [3:0]  erx_rxd,
  input  logic        erx_dv,
  input  logic        erx_er,
  input  logic        erx_cs,
  input  logic [3:0]  erx_cmd,
  output logic [31:0] erx_data,
  output logic        erx_ready,
  output logic        erx_avail,
  output logic [7:0]  erx_debug
);

  localparam int unsigned DEPTH       = MAX_BYTES / 4;
  localparam int unsigned AW          = $clog2(DEPTH);
  localparam logic [10:0] CNT_SAT     = 11'(MAX_BYTES - 1);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] CHECK    = 3'd3;
  localparam logic [2:0] DISCARD  = 3'd4;

  logic [2:0]    state;
  logic          dv_prev;
  logic          nib_hi;
  logic [3:0]    lo_nib;
  logic [10:0]   byte_cnt;
  logic [31:0]   word_buf;
  logic [31:0]   crc;
  logic          too_long;
  logic          er_seen;
  logic [10:0]   size;
  logic [15:0]   drop_cnt;

  logic [7:0]    new_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          frame_good;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word;
  logic [1:0]    h_stage;
  logic [3:0]    cmd_q;
  logic [AW:0]   rd_ptr;
  logic          release_fire;

  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 4; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign new_byte   = {erx_rxd, lo_nib};
  assign wr_addr    = byte_cnt[AW+1:2];
  assign frame_good = (state == CHECK) && (crc == CRC_RESIDUE) && !nib_hi &&
                      (byte_cnt >= 11'd64) && !too_long && !er_seen;

  // The 2048th byte cannot be represented in the 11-bit size and is treated as overflow.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = word_buf;
    if (state == DATA && !too_long) begin
      if (erx_dv && nib_hi && byte_cnt[1:0] == 2'd3 && byte_cnt != CNT_SAT) begin
        wr_en   = 1'b1;
        wr_data = {new_byte, word_buf[23:0]};
      end else if (!erx_dv && byte_cnt[1:0] != 2'd0) begin
        wr_en = 1'b1;
      end
    end
  end

  // dv_prev resets high so a frame already in flight at reset release is discarded.
  always_ff @(posedge erx_clk or posedge erx_rst) begin
    if (erx_rst) begin
      state     <= IDLE;
      dv_prev   <= 1'b1;
      nib_hi    <= 1'b0;
      lo_nib    <= '0;
      byte_cnt  <= '0;
      word_buf  <= '0;
      crc       <= '1;
      too_long  <= 1'b0;
      er_seen   <= 1'b0;
      size      <= '0;
      drop_cnt  <= '0;
      erx_debug <= '0;
    end else begin
      dv_prev <= erx_dv;
      case (state)
        IDLE: begin
          if (erx_dv)
            state <= (erx_rxd == 4'h5 && !dv_prev) ? PREAMBLE : DISCARD;
        end
        PREAMBLE: begin
          if (!erx_dv) begin
            state <= IDLE;
          end else if (erx_rxd == 4'hD) begin
            if (erx_avail) begin
              state <= DISCARD;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
            end else begin
              state    <= DATA;
              byte_cnt <= '0;
              nib_hi   <= 1'b0;
              word_buf <= '0;
              crc      <= '1;
              too_long <= 1'b0;
              er_seen  <= 1'b0;
            end
          end else if (erx_rxd != 4'h5) begin
            state <= DISCARD;
          end
        end
        DATA: begin
          if (erx_er) er_seen <= 1'b1;
          if (erx_dv) begin
            crc    <= crc_nib(crc, erx_rxd);
            nib_hi <= ~nib_hi;
            if (!nib_hi) begin
              lo_nib <= erx_rxd;
            end else begin
              if (byte_cnt == CNT_SAT) too_long <= 1'b1;
              else                     byte_cnt <= byte_cnt + 11'd1;
              if (byte_cnt[1:0] == 2'd3) word_buf <= '0;
              else word_buf[{byte_cnt[1:0], 3'b000} +: 8] <= new_byte;
            end
          end else begin
            state <= CHECK;
          end
        end
        CHECK: begin
          erx_debug <= byte_cnt[7:0];
          if (frame_good) size <= byte_cnt;
          state <= IDLE;
        end
        DISCARD: begin
          if (!erx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign release_fire = (h_stage == 2'd2) && (cmd_q == ERX_CMD_RELEASE);

  // A frame completing in the same cycle as a release keeps the buffer valid.
  always_ff @(posedge erx_clk or posedge erx_rst) begin
    if (erx_rst)           erx_avail <= 1'b0;
    else if (frame_good)   erx_avail <= 1'b1;
    else if (release_fire) erx_avail <= 1'b0;
  end

  always_ff @(posedge erx_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (h_stage == 2'd1) rd_word <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge erx_clk or posedge erx_rst) begin
    if (erx_rst) begin
      h_stage   <= '0;
      cmd_q     <= '0;
      erx_data  <= '0;
      erx_ready <= 1'b0;
      rd_ptr    <= '0;
    end else begin
      case (h_stage)
        2'd0: begin
          if (erx_cs) begin
            cmd_q   <= erx_cmd;
            h_stage <= 2'd1;
          end
        end
        2'd1: h_stage <= 2'd2;
        2'd2: begin
          h_stage   <= 2'd0;
          erx_ready <= ~erx_ready;
          case (cmd_q)
            ERX_CMD_GETSIZE: begin
              erx_data <= {erx_avail, 20'b0, size};
              rd_ptr   <= '0;
            end
            ERX_CMD_GETDATA: begin
              // Word k is valid while 4*k is below the byte size.
              if ({rd_ptr, 2'b00} < {1'b0, size}) begin
                erx_data <= {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]};
                rd_ptr   <= rd_ptr + 1'b1;
              end else begin
                erx_data <= '0;
              end
            end
            ERX_CMD_RELEASE: begin
              erx_data <= '0;
              rd_ptr   <= '0;
            end
            ERX_CMD_GETDROP: erx_data <= {16'b0, drop_cnt};
            default:         erx_data <= '0;
          endcase
        end
        default: h_stage <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ether_rx.sv
// Directed bench for ether_rx: MII frames built with a bytewise CRC-32 model,
// host command results checked from a scoreboard queue.
module tb_ether_rx;

  logic        erx_clk = 1'b0;
  logic        erx_rst;
  logic [3:0]  erx_rxd;
  logic        erx_dv;
  logic        erx_er;
  logic        erx_cs;
  logic [3:0]  erx_cmd;
  logic [31:0] erx_data;
  logic        erx_ready;
  logic        erx_avail;
  logic [7:0]  erx_debug;

  localparam logic [3:0] C_SIZE = 4'd1;
  localparam logic [3:0] C_DATA = 4'd2;
  localparam logic [3:0] C_REL  = 4'd3;
  localparam logic [3:0] C_DROP = 4'd4;

  int tests = 0;
  int fails = 0;

  logic [7:0]  frame [0:2199];
  int          frame_len;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [31:0] saved_w0;

  ether_rx #(.ERX_CMD_GETSIZE(4'd1), .ERX_CMD_GETDATA(4'd2), .ERX_CMD_RELEASE(4'd3),
             .ERX_CMD_GETDROP(4'd4), .MAX_BYTES(2048)) dut (
    .erx_clk(erx_clk), .erx_rst(erx_rst), .erx_rxd(erx_rxd), .erx_dv(erx_dv),
    .erx_er(erx_er), .erx_cs(erx_cs), .erx_cmd(erx_cmd), .erx_data(erx_data),
    .erx_ready(erx_ready), .erx_avail(erx_avail), .erx_debug(erx_debug)
  );

  always #5 erx_clk = ~erx_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'b0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int n, input int seed);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n - 4; i++) begin
      frame[i] = 8'(i * 13 + seed);
      c = crc_byte(c, frame[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) frame[n - 4 + k] = c[8*k +: 8];
    frame_len = n;
  endtask

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++)
      w = {w[23:0], ((4*k + j) < frame_len) ? frame[4*k + j] : 8'h00};
    return w;
  endfunction

  task automatic send_frame(input int er_at, input int rst_at);
    logic [7:0] b;
    for (int i = 0; i < 15; i++) begin
      erx_dv = 1'b1; erx_rxd = 4'h5;
      @(negedge erx_clk);
    end
    erx_rxd = 4'hD;
    @(negedge erx_clk);
    for (int i = 0; i < 2 * frame_len; i++) begin
      b = frame[i / 2];
      erx_rxd = (i % 2 == 0) ? b[3:0] : b[7:4];
      erx_er  = (i == er_at);
      if (i == rst_at)     erx_rst = 1'b1;
      if (i == rst_at + 3) erx_rst = 1'b0;
      @(negedge erx_clk);
    end
    erx_dv = 1'b0; erx_er = 1'b0; erx_rxd = 4'h0;
    repeat (16) @(negedge erx_clk);
  endtask

  task automatic host_cmd(input logic [3:0] cmd, input logic [31:0] exp, input string tag,
                          input logic dbl);
    logic        prev;
    int          lat;
    logic [31:0] e;
    string       t;
    prev = erx_ready;
    erx_cs = 1'b1; erx_cmd = cmd;
    exp_q.push_back(exp); tag_q.push_back(tag);
    @(negedge erx_clk);
    erx_cs = dbl;
    lat = 1;
    while (erx_ready === prev && lat < 8) begin
      @(negedge erx_clk);
      erx_cs = 1'b0;
      lat++;
    end
    erx_cs = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd3);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, erx_data, e);
    repeat (3) @(negedge erx_clk);
    check({tag, "_once"}, {31'b0, erx_ready}, {31'b0, ~prev});
  endtask

  initial begin
    erx_rst = 1'b1; erx_rxd = '0; erx_dv = 1'b0; erx_er = 1'b0;
    erx_cs = 1'b0; erx_cmd = '0;
    repeat (3) @(negedge erx_clk);
    erx_rst = 1'b0;
    @(negedge erx_clk);
    check("rst_data",  erx_data, 32'h0);
    check("rst_ready", {31'b0, erx_ready}, 32'h0);
    check("rst_avail", {31'b0, erx_avail}, 32'h0);
    check("rst_debug", {24'b0, erx_debug}, 32'h0);
    host_cmd(C_SIZE, 32'h0, "size_empty", 1'b0);
    host_cmd(C_DROP, 32'h0, "drop_rst", 1'b0);

    build_frame(64, 1);
    send_frame(-1, -1);
    check("good64_avail", {31'b0, erx_avail}, 32'h1);
    check("good64_debug", {24'b0, erx_debug}, 32'h40);
    host_cmd(C_SIZE, 32'h80000040, "size64", 1'b1);
    for (int k = 0; k < 16; k++) host_cmd(C_DATA, exp_word(k), "data64", 1'b0);
    host_cmd(C_DATA, 32'h0, "data64_past", 1'b0);
    host_cmd(C_REL, 32'h0, "release64", 1'b0);
    check("release_avail", {31'b0, erx_avail}, 32'h0);

    build_frame(64, 2);
    frame[10] = frame[10] ^ 8'h08;
    send_frame(-1, -1);
    check("badcrc_avail", {31'b0, erx_avail}, 32'h0);
    host_cmd(C_DROP, 32'h0, "drop_badcrc", 1'b0);

    build_frame(70, 3);
    send_frame(-1, -1);
    check("good70_avail", {31'b0, erx_avail}, 32'h1);
    host_cmd(C_SIZE, 32'h80000046, "size70", 1'b0);
    for (int k = 0; k < 18; k++) host_cmd(C_DATA, exp_word(k), "data70", 1'b0);
    host_cmd(C_DATA, 32'h0, "data70_past", 1'b0);
    saved_w0 = exp_word(0);

    build_frame(64, 4);
    send_frame(-1, -1);
    check("drop_avail", {31'b0, erx_avail}, 32'h1);
    host_cmd(C_DROP, 32'h1, "drop_one", 1'b0);
    host_cmd(C_SIZE, 32'h80000046, "size_kept", 1'b0);
    host_cmd(C_DATA, saved_w0, "data_kept", 1'b0);
    host_cmd(C_REL, 32'h0, "release70", 1'b0);

    build_frame(64, 5);
    send_frame(30, -1);
    check("er_avail", {31'b0, erx_avail}, 32'h0);

    build_frame(2100, 6);
    send_frame(-1, -1);
    check("long_avail", {31'b0, erx_avail}, 32'h0);
    check("long_debug", {24'b0, erx_debug}, 32'hFF);

    build_frame(60, 7);
    send_frame(-1, -1);
    check("runt_avail", {31'b0, erx_avail}, 32'h0);
    check("runt_debug", {24'b0, erx_debug}, 32'h3C);

    build_frame(64, 8);
    send_frame(-1, 40);
    check("rstmid_avail", {31'b0, erx_avail}, 32'h0);
    check("rstmid_debug", {24'b0, erx_debug}, 32'h0);
    host_cmd(C_SIZE, 32'h0, "rstmid_size", 1'b0);
    host_cmd(C_DROP, 32'h0, "rstmid_drop", 1'b0);

    build_frame(64, 9);
    send_frame(-1, -1);
    check("after_avail", {31'b0, erx_avail}, 32'h1);
    host_cmd(C_SIZE, 32'h80000040, "after_size", 1'b0);
    host_cmd(C_DATA, exp_word(0), "after_data0", 1'b0);
    host_cmd(C_DATA, exp_word(1), "after_data1", 1'b0);
    host_cmd(4'hF, 32'h0, "unknown_cmd", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
ETHER_RX -- requirements
Module: ether_rx

Interface
REQ-001 Parameter ERX_CMD_GETSIZE, 1, host command: return frame status/size word.
REQ-002 Parameter ERX_CMD_GETDATA, 2, host command: return next buffered data word.
REQ-003 Parameter ERX_CMD_RELEASE, 3, host command: free receive buffer.
REQ-004 Parameter ERX_CMD_GETDROP, 4, host command: return dropped-frame count.
REQ-005 Parameter MAX_BYTES, 2048, frame buffer capacity in bytes (512 x 32-bit words).
REQ-006 The block SHALL have one clock, erx_clk, and reset erx_rst, asynchronous, active-high; all state updates occur on the rising edge of erx_clk.
REQ-007 Ports, one per line (name  direction  width  meaning):
- erx_clk  in  1  MII receive clock
- erx_rst  in  1  async active-high reset
- erx_rxd  in  4  MII receive nibble
- erx_dv  in  1  MII receive data valid
- erx_er  in  1  MII receive error
- erx_cs  in  1  host command strobe, one cycle
- erx_cmd  in  4  host command code
- erx_data  out  32  host read data
- erx_ready  out  1  toggles once per completed host command
- erx_avail  out  1  level: valid frame held in buffer
- erx_debug  out  8  low 8 bits of last frame byte count

Function
REQ-008 Receive FSM states SHALL be IDLE, PREAMBLE, DATA, CHECK, DISCARD.
REQ-009 IDLE: on erx_dv=1 with erx_rxd=0x5 go PREAMBLE; with any other nibble go DISCARD.
REQ-010 PREAMBLE: nibble 0x5 stays; 0xD (SFD) goes DATA with byte count 0 and CRC register 0xFFFFFFFF; any other nibble or erx_dv=0 goes DISCARD/IDLE respectively.
REQ-011 DATA: nibbles assemble low nibble first into bytes; bytes pack into words with first byte in bits [7:0]; each completed word is written to buffer address count/4.
REQ-012 CRC SHALL be reflected CRC-32 (poly 0xEDB88320), updated 4 bits per cycle LSB first over all bytes including FCS.
REQ-013 erx_dv falling in DATA goes CHECK; a partial final word is written with unused bytes zero.
REQ-014 CHECK (one cycle): frame good iff CRC register = 0xDEBB20E3, nibble count even, byte count 64..MAX_BYTES, erx_er never asserted in DATA; good: erx_avail<=1, size latched; bad: buffer not marked valid.
REQ-015 Byte count exceeding MAX_BYTES SHALL stop buffer writes and force frame bad; counter saturates at 2047.
REQ-016 Frame start (SFD) while erx_avail=1 SHALL go DISCARD and increment drop counter (16-bit, saturating at 0xFFFF).
REQ-017 DISCARD: waits for erx_dv=0, then IDLE; no buffer writes.
REQ-018 Host: erx_cs sampled only when host idle; erx_cs while a command is in progress is ignored; erx_data valid when erx_ready toggles, 2 cycles after erx_cs.
REQ-019 GETSIZE returns {erx_avail, 20'b0, size[10:0]}; resets read pointer to 0.
REQ-020 GETDATA returns buffer word at read pointer byte-swapped (first frame byte in [31:24]), pointer +1; pointer past size returns 0x00000000.
REQ-021 RELEASE clears erx_avail and read pointer; a frame already in DISCARD stays discarded.
REQ-022 Unknown command codes SHALL still toggle erx_ready with erx_data=0.
REQ-023 Host read and receive write to buffer in the same cycle SHALL both complete (dual-port buffer).

Reset
REQ-024 erx_rst SHALL force IDLE, erx_ready=0, erx_data=0, erx_avail=0, erx_debug=0, size=0, read pointer=0, drop counter=0, mid-frame data abandoned.
REQ-025 Deassertion during erx_dv=1 SHALL enter DISCARD until erx_dv=0.

Verification
REQ-026 64-byte frame, 7x0x55+0xD5 preamble, correct FCS -> erx_avail=1, GETSIZE=0x80000040, first GETDATA = first four bytes MSB-first.
REQ-027 Same frame with one payload bit flipped -> erx_avail stays 0, drop counter 0.
REQ-028 Second good frame while erx_avail=1 -> GETDROP=0x00000001, first frame data intact.
REQ-029 erx_er pulsed mid-DATA on good-FCS frame -> erx_avail=0.
REQ-030 2100-byte frame -> rejected, no write beyond address 511; following 60-byte frame -> rejected (runt).
REQ-031 erx_rst asserted mid-frame then released with erx_dv=1 -> frame ignored; next good frame accepted, erx_ready toggles once per command.
